// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : MEM pipeline stage. Byte/half/word loads and stores into a
//                local 32-bit data memory with a configurable wait-state
//                count, branch-taken resolution and a registered MEM/WB
//                boundary.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_valid,
    input  logic [1:0]  MEM_ctlwb,
    input  logic        MEM_memread,
    input  logic        MEM_memwrite,
    input  logic        MEM_branch,
    input  logic [1:0]  MEM_size,
    input  logic        MEM_unsigned,
    input  logic        MEM_alu_zero,
    input  logic [31:0] MEM_alu_out,
    input  logic [31:0] MEM_rd2,
    input  logic [4:0]  MEM_rd,
    output logic        MEM_stall,
    output logic        MEM_PCSrc,
    output logic        WB_valid,
    output logic [1:0]  WB_ctlwb,
    output logic [31:0] WB_rdata,
    output logic [31:0] WB_alu_out,
    output logic [4:0]  WB_rd,
    output logic        WB_misalign
);

    localparam int         c_DEPTH    = 1 << ADDR_W;
    localparam bit         c_HAS_WAIT = (WAIT_CYCLES > 0);
    localparam logic [3:0] c_CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [3:0]         r_cnt;
    logic [3:0]         w_cnt_nxt;
    logic               w_stall;
    logic               w_complete;

    logic [31:0]        r_mem [c_DEPTH];

    logic               r_wb_valid;
    logic [1:0]         r_wb_ctlwb;
    logic [31:0]        r_wb_rdata;
    logic [31:0]        r_wb_alu_out;
    logic [4:0]         r_wb_rd;
    logic               r_wb_misalign;

    logic [ADDR_W-1:0]  w_idx;
    logic [1:0]         w_lane;
    logic               w_is_half;
    logic               w_is_word;
    logic               w_misalign;
    logic               w_mem_op;
    logic               w_is_store;
    logic               w_is_load;
    logic [31:0]        w_word;
    logic [31:0]        w_shift;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_ld_data;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic               w_unused_addr;

    // Address decode: upper address bits are dropped so accesses wrap.
    assign w_idx         = MEM_alu_out[ADDR_W+1:2];
    assign w_lane        = MEM_alu_out[1:0];
    assign w_unused_addr = ^MEM_alu_out[31:ADDR_W+2];

    // Size 11 falls into the word case.
    assign w_is_word  = MEM_size[1];
    assign w_is_half  = (MEM_size == 2'b01);
    assign w_misalign = MEM_valid & (MEM_memread | MEM_memwrite) &
                        ((w_is_half & w_lane[0]) | (w_is_word & (w_lane != 2'b00)));
    assign w_mem_op   = MEM_valid & (MEM_memread | MEM_memwrite) & ~w_misalign;
    // Read+write together behaves as a pure store.
    assign w_is_store = w_mem_op & MEM_memwrite;
    assign w_is_load  = w_mem_op & MEM_memread & ~MEM_memwrite;

    assign MEM_PCSrc = MEM_valid & MEM_branch & MEM_alu_zero;
    assign MEM_stall = w_stall;

    // Little-endian lane extraction for loads.
    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_lane, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = w_lane[1] ? w_word[31:16] : w_word[15:0];

    // Load data extension and store lane enables / replicated write data.
    always_comb begin
        w_ld_data = w_word;
        w_be      = 4'b1111;
        w_wdata   = MEM_rd2;
        case (MEM_size)
            2'b00: begin
                w_ld_data = MEM_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
                w_be      = 4'b0001 << w_lane;
                w_wdata   = {4{MEM_rd2[7:0]}};
            end
            2'b01: begin
                w_ld_data = MEM_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
                w_be      = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{MEM_rd2[15:0]}};
            end
            default: begin
                w_ld_data = w_word;
                w_be      = 4'b1111;
                w_wdata   = MEM_rd2;
            end
        endcase
    end

    // Wait-state FSM: decides stall and which edge completes the access.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op && c_HAS_WAIT) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = c_CNT_INIT;
                    w_stall     = 1'b1;
                end else begin
                    w_complete  = 1'b1;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                    w_complete  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                    w_stall     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and MEM/WB pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_wb_valid    <= 1'b0;
            r_wb_ctlwb    <= 2'b00;
            r_wb_rdata    <= 32'd0;
            r_wb_alu_out  <= 32'd0;
            r_wb_rd       <= 5'd0;
            r_wb_misalign <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_complete) begin
                r_wb_valid    <= MEM_valid;
                r_wb_ctlwb    <= (MEM_valid && !w_misalign) ? MEM_ctlwb : 2'b00;
                r_wb_rdata    <= w_is_load ? w_ld_data : 32'd0;
                r_wb_alu_out  <= MEM_alu_out;
                r_wb_rd       <= MEM_rd;
                r_wb_misalign <= w_misalign;
            end else begin
                r_wb_valid    <= 1'b0;
                r_wb_ctlwb    <= 2'b00;
                r_wb_misalign <= 1'b0;
            end
        end
    end

    // Data memory write: only on the completing edge, never while in reset.
    always_ff @(posedge clk) begin
        if (!rst && w_complete && w_is_store) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    assign WB_valid    = r_wb_valid;
    assign WB_ctlwb    = r_wb_ctlwb;
    assign WB_rdata    = r_wb_rdata;
    assign WB_alu_out  = r_wb_alu_out;
    assign WB_rd       = r_wb_rd;
    assign WB_misalign = r_wb_misalign;

endmodule
`default_nettype wire
